// File: rtl/chunked_compare_ctrl.sv
// chunked_compare_ctrl: compares two W*K-bit unsigned operands using one
// W-bit comparator. Each RUN cycle compares one chunk, starting at the MSB chunk.
// Input and result sides both use valid/ready handshakes.
// Optional macro CHUNK_CMP_EARLY_EXIT_EN: stop RUN at the first unequal chunk.
// Without it, RUN always takes K cycles (constant latency).

// Single W-bit comparator slice, time-shared across chunks.
module chunk_cmp #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         lt_o
);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);
endmodule

module chunked_compare_ctrl #(
    parameter int unsigned W = 8,
    parameter int unsigned K = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W*K-1:0]           a,
    input  logic [W*K-1:0]           b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     eq,
    output logic                     lt,
    output logic [$clog2(K+1)-1:0]   ncmp,
    output logic                     busy
);
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = $clog2(K + 1);

`ifdef CHUNK_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [K-1:0][W-1:0]  a_q, b_q;
    logic [IW-1:0]        idx_q;
    logic                 decided_q, ltr_q;
    logic [CW-1:0]        cnt_q;
    logic                 eq_q, lt_q;
    logic [CW-1:0]        ncmp_q;

    logic                 c_eq, c_lt;
    logic [CW-1:0]        cnt_d;
    logic                 decided_d, ltr_d, exit_d;

    chunk_cmp #(.W(W)) u_cmp (
        .a_i  (a_q[idx_q]),
        .b_i  (b_q[idx_q]),
        .eq_o (c_eq),
        .lt_o (c_lt)
    );

    // Per-chunk update: the first unequal chunk decides the result, and later chunks cannot change it.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        decided_d = decided_q | ~c_eq;
        ltr_d     = decided_q ? ltr_q : c_lt;
        exit_d    = (idx_q == '0) || (EARLY && !c_eq);
    end

    // Sequencer FSM. The result fields are registered on RUN exit and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            ltr_q     <= 1'b0;
            cnt_q     <= '0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ncmp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        idx_q     <= IW'(K - 1);
                        decided_q <= 1'b0;
                        ltr_q     <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    cnt_q     <= cnt_d;
                    decided_q <= decided_d;
                    ltr_q     <= ltr_d;
                    if (exit_d) begin
                        eq_q    <= ~decided_d;
                        lt_q    <= ltr_d;
                        ncmp_q  <= cnt_d;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign ncmp      = ncmp_q;
endmodule
